skynet_div_seq_20s11s: RTL and testbench

SKYNET_DIV_SEQ_20S11S -- requirements
Module: skynet_div_seq_20s11s

---
 rtl/skynet_div_seq_20s11s.sv | 166 ++++++++++++++++
 tb/tb_skynet_div_seq_20s11s.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/skynet_div_seq_20s11s.sv
// Sequential signed divider: 20-bit dividend / 11-bit divisor, restoring
// algorithm one bit per cycle, quotient saturated to 9 bits signed.
// Valid/ready handshake on both sides; one operation in flight at a time.
module skynet_div_seq_20s11s #(
    parameter int DIVIDEND_W = 20,
    parameter int DIVISOR_W  = 11,
    parameter int QUOT_W     = 9
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  ovf,
    output logic                  dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    // Saturation limits of the signed quotient
    localparam logic [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W-1){1'b0}}};
    localparam logic [DIVIDEND_W:0] Q_MAX_W = {{(DIVIDEND_W-QUOT_W+2){1'b0}}, {(QUOT_W-1){1'b1}}};
    localparam logic [DIVIDEND_W:0] Q_MIN_MAG = {{(DIVIDEND_W-QUOT_W+1){1'b0}}, 1'b1, {(QUOT_W-1){1'b0}}};

    state_t state, state_nxt;

    logic                  sign_a;
    logic                  sign_b;
    logic                  div_zero;
    logic [DIVISOR_W:0]    dmag;      // |divisor|, one extra bit so -1024 fits
    logic [DIVIDEND_W:0]   mag_q;     // |dividend| shifting out, quotient shifting in
    logic [DIVISOR_W-1:0]  r_sh;      // partial remainder magnitude, always < |divisor|
    logic [CNT_W-1:0]      cnt;

    logic [DIVIDEND_W:0]   amag;
    logic [DIVISOR_W:0]    bmag;
    logic [DIVISOR_W:0]    trial;
    logic                  trial_ge;
    logic [DIVISOR_W-1:0]  trial_sub;
    logic [QUOT_W-1:0]     fix_q;
    logic [DIVISOR_W-1:0]  fix_r;
    logic                  fix_ovf;

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes at one extra bit so the most negative values do not wrap
    always_comb begin
        amag = dividend[DIVIDEND_W-1] ? -{dividend[DIVIDEND_W-1], dividend}
                                      :  {dividend[DIVIDEND_W-1], dividend};
        bmag = divisor[DIVISOR_W-1]   ? -{divisor[DIVISOR_W-1], divisor}
                                      :  {divisor[DIVISOR_W-1], divisor};
    end

    // One restoring step: bring down the next dividend bit and try to subtract.
    // The subtraction is done modulo 2^DIVISOR_W; when it succeeds the true
    // difference is below |divisor| and therefore fits.
    always_comb begin
        trial     = {r_sh, mag_q[DIVIDEND_W-1]};
        trial_ge  = (trial >= dmag);
        trial_sub = trial[DIVISOR_W-1:0] - dmag[DIVISOR_W-1:0];
    end

    // Sign application and saturation for the final result
    always_comb begin
        fix_q   = '0;
        fix_ovf = 1'b0;
        fix_r   = sign_a ? -r_sh : r_sh;
        if (div_zero) begin
            fix_q = sign_a ? Q_MIN : Q_MAX;
            fix_r = '0;
        end else if (sign_a ^ sign_b) begin
            if (mag_q > Q_MIN_MAG) begin
                fix_q   = Q_MIN;
                fix_ovf = 1'b1;
            end else begin
                fix_q = -mag_q[QUOT_W-1:0];
            end
        end else begin
            if (mag_q > Q_MAX_W) begin
                fix_q   = Q_MAX;
                fix_ovf = 1'b1;
            end else begin
                fix_q = mag_q[QUOT_W-1:0];
            end
        end
    end

    // Datapath: operand capture, iteration, and output registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            dmag      <= '0;
            mag_q     <= '0;
            r_sh      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_a   <= dividend[DIVIDEND_W-1];
                    sign_b   <= divisor[DIVISOR_W-1];
                    div_zero <= (divisor == '0);
                    dmag     <= bmag;
                    mag_q    <= amag;
                    r_sh     <= '0;
                    cnt      <= CNT_W'(DIVIDEND_W);
                end
                CALC: if (cnt != '0) begin
                    mag_q <= {1'b0, mag_q[DIVIDEND_W-2:0], trial_ge};
                    r_sh  <= trial_ge ? trial_sub : trial[DIVISOR_W-1:0];
                    cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    quotient  <= fix_q;
                    remainder <= fix_r;
                    ovf       <= fix_ovf;
                    dz        <= div_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_skynet_div_seq_20s11s.sv
// Directed bench for skynet_div_seq_20s11s: hand-computed quotient/remainder
// vectors, saturation and divide-by-zero cases, backpressure and mid-op reset.
module tb_skynet_div_seq_20s11s;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] dividend;
    logic [10:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  quotient;
    logic [10:0] remainder;
    logic        ovf;
    logic        dz;

    int errors = 0;
    int checks = 0;

    skynet_div_seq_20s11s #(
        .DIVIDEND_W(20),
        .DIVISOR_W (11),
        .QUOT_W    (9)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .ovf      (ovf),
        .dz       (dz)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Waits for out_valid after an accept edge; returns edges counted
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge ap_clk);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic handshake(input string tag);
        @(negedge ap_clk);
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, ".ov_after_hs"}, int'(out_valid), 0);
        check_eq({tag, ".rdy_after_hs"}, int'(in_ready), 1);
    endtask

    task automatic start_op(input int a, input int b);
        int n;
        @(negedge ap_clk);
        in_valid = 1'b1;
        dividend = a[19:0];
        divisor  = b[10:0];
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input int a, input int b,
                          input int eq, input int er, input int eovf, input int edz);
        int lat;
        start_op(a, b);
        wait_result(lat);
        check_eq({tag, ".lat"}, lat, 22);
        check_eq({tag, ".q"}, int'($signed(quotient)), eq);
        check_eq({tag, ".r"}, int'($signed(remainder)), er);
        check_eq({tag, ".ovf"}, int'(ovf), eovf);
        check_eq({tag, ".dz"}, int'(dz), edz);
        handshake(tag);
    endtask

    initial begin
        int lat;
        int bad_rdy;
        int bad_hold;
        logic [8:0]  hq;
        logic [10:0] hr;
        logic        hovf;
        logic        hdz;

        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        check_eq("rst.ov", int'(out_valid), 0);
        check_eq("rst.q", int'(quotient), 0);
        check_eq("rst.r", int'(remainder), 0);
        check_eq("rst.flags", int'({ovf, dz}), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        check_eq("rst.rdy", int'(in_ready), 1);

        // Signed truncating division
        run_op("p_p", 1000, 7, 142, 6, 0, 0);
        run_op("n_p", -1000, 7, -142, -6, 0, 0);
        run_op("p_n", 1000, -7, -142, 6, 0, 0);
        run_op("n_n", -1000, -7, 142, -6, 0, 0);
        run_op("small", 5, 9, 0, 5, 0, 0);
        run_op("neg_small", -5, 9, 0, -5, 0, 0);
        run_op("pos_edge", 255, 1, 255, 0, 0, 0);
        run_op("neg_edge", -256, 1, -256, 0, 0, 0);
        run_op("min_div", 1024, -1024, -1, 0, 0, 0);

        // Saturation
        run_op("sat_hi", 100000, 3, 255, 1, 1, 0);
        run_op("sat_min", -524288, -1, 255, 0, 1, 0);
        run_op("sat_lo", -524288, 1023, -256, -512, 1, 0);
        run_op("sat_257", -257, 1, -256, 0, 1, 0);

        // Divide by zero
        run_op("dz_neg", -5, 0, -256, 0, 0, 1);
        run_op("dz_zero", 0, 0, 255, 0, 0, 1);

        // Backpressure with in_valid held high
        start_op(1000, 7);
        in_valid = 1'b1;
        dividend = -20'sd1000;
        divisor  = 11'sd7;
        bad_rdy  = 0;
        lat      = 0;
        do begin
            if (in_ready) bad_rdy++;
            @(posedge ap_clk);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
        check_eq("bp.lat", lat, 22);
        check_eq("bp.q", int'($signed(quotient)), 142);
        check_eq("bp.r", int'($signed(remainder)), 6);
        hq = quotient; hr = remainder; hovf = ovf; hdz = dz;
        bad_hold = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge ap_clk);
            #1;
            if (in_ready) bad_rdy++;
            if (!out_valid || quotient !== hq || remainder !== hr || ovf !== hovf || dz !== hdz)
                bad_hold++;
        end
        check_eq("bp.rdy_low", bad_rdy, 0);
        check_eq("bp.hold", bad_hold, 0);
        @(negedge ap_clk);
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        check_eq("bp.rdy_idle", int'(in_ready), 1);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        check_eq("bp.accepted", int'(in_ready), 0);
        wait_result(lat);
        check_eq("bp2.lat", lat, 22);
        check_eq("bp2.q", int'($signed(quotient)), -142);
        check_eq("bp2.r", int'($signed(remainder)), -6);
        handshake("bp2");

        // Reset in the middle of an operation
        start_op(100000, 3);
        repeat (9) @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check_eq("mrst.ov", int'(out_valid), 0);
        check_eq("mrst.q", int'(quotient), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        check_eq("mrst.rdy", int'(in_ready), 1);
        bad_rdy = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge ap_clk);
            #1;
            if (out_valid || !in_ready) bad_rdy++;
        end
        check_eq("mrst.no_result", bad_rdy, 0);
        run_op("after_rst", 1000, 7, 142, 6, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
